// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception/interrupt coprocessor: cause codes,
// exception state encoding and the default datapath width.
package exception_unit_pkg;

  localparam int unsigned WIDTH_DEF      = 16;
  localparam int unsigned CAUSE_SYSCALL  = 0;
  localparam int unsigned CAUSE_ILLEGAL  = 1;
  localparam int unsigned CAUSE_IRQ_BASE = 8;
  localparam int unsigned CAUSE_EXT_BIT  = 15;
  localparam int unsigned IRQ_IDX_W      = 3;

  typedef enum logic [1:0] {
    EXC_IDLE,
    EXC_PENDING,
    EXC_HANDLER
  } exc_state_e;

  // Low nibble of the Cause code for an external interrupt line.
  function automatic logic [3:0] irq_code(input logic [IRQ_IDX_W-1:0] idx);
    return 4'(CAUSE_IRQ_BASE + 32'(idx));
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Control-unit / datapath facing signals of the exception unit.
interface exception_unit_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_IRQ = 4
);

  logic [WIDTH-1:0]   PC;
  logic               IntCause;
  logic               CauseWrite;
  logic               EPCWrite;
  logic               InstrBoundary;
  logic               Eret;
  logic               MaskWrite;
  logic [NUM_IRQ-1:0] MaskData;
  logic [NUM_IRQ-1:0] ExtIrq;

  logic               ExcPending;
  logic [WIDTH-1:0]   EPC;
  logic [WIDTH-1:0]   Cause;
  logic [WIDTH-1:0]   HandlerVector;
  logic               IntEnable;
  logic               InHandler;
  logic [NUM_IRQ-1:0] IrqAck;

  modport master (
    output PC, IntCause, CauseWrite, EPCWrite, InstrBoundary, Eret,
           MaskWrite, MaskData, ExtIrq,
    input  ExcPending, EPC, Cause, HandlerVector, IntEnable, InHandler, IrqAck
  );

  modport slave (
    input  PC, IntCause, CauseWrite, EPCWrite, InstrBoundary, Eret,
           MaskWrite, MaskData, ExtIrq,
    output ExcPending, EPC, Cause, HandlerVector, IntEnable, InHandler, IrqAck
  );

endinterface

// File: rtl/exception_unit_irq_latch_prio.sv
// Per-line rising-edge latches, interrupt mask and lowest-index priority
// select for the exception unit.
module irq_latch_prio
  import exception_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [NUM_IRQ-1:0]   extIrq,
  input  logic                 maskWrite,
  input  logic [NUM_IRQ-1:0]   maskData,
  input  logic                 clrStrobe,
  input  logic [IRQ_IDX_W-1:0] clrIndex,
  output logic                 anyActive,
  output logic [IRQ_IDX_W-1:0] selIndex
);

  logic [NUM_IRQ-1:0] prevIrq;
  logic [NUM_IRQ-1:0] irqLatch;
  logic [NUM_IRQ-1:0] irqMask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clrVec;
  logic [NUM_IRQ-1:0] active;

  assign rise   = extIrq & ~prevIrq;
  assign clrVec = clrStrobe ? (NUM_IRQ'(1) << clrIndex) : '0;
  assign active = irqLatch & irqMask;

  // A fresh edge on the line being cleared keeps the latch set.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      prevIrq  <= '0;
      irqLatch <= '0;
      irqMask  <= '1;
    end else begin
      prevIrq  <= extIrq;
      irqLatch <= (irqLatch & ~clrVec) | rise;
      if (maskWrite) irqMask <= maskData;
    end
  end

  always_comb begin
    anyActive = |active;
    selIndex  = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (active[i-1]) selIndex = IRQ_IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt coprocessor: EPC and Cause registers, interrupt
// acceptance at instruction boundaries and handler entry/exit tracking.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter int unsigned      WIDTH        = WIDTH_DEF,
  parameter int unsigned      NUM_IRQ      = 4,
  parameter logic [WIDTH-1:0] HANDLER_ADDR = WIDTH'(16'h0100)
) (
  input logic CLK,
  input logic Reset,
  exception_unit_if.slave bus
);

  exc_state_e state, nextState;

  logic [IRQ_IDX_W-1:0] frozenIdx;
  logic [IRQ_IDX_W-1:0] selIndex;
  logic                 anyActive;
  logic                 excPending;
  logic                 inHandler;
  logic                 intEnable;
  logic                 irqService;
  logic [NUM_IRQ-1:0]   irqAck;
  logic [WIDTH-1:0]     epcReg;
  logic [WIDTH-1:0]     causeReg;
  logic [WIDTH-1:0]     causeIrq;
  logic [WIDTH-1:0]     causeSw;

  irq_latch_prio #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .CLK       (CLK),
    .Reset     (Reset),
    .extIrq    (bus.ExtIrq),
    .maskWrite (bus.MaskWrite),
    .maskData  (bus.MaskData),
    .clrStrobe (irqService),
    .clrIndex  (frozenIdx),
    .anyActive (anyActive),
    .selIndex  (selIndex)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= EXC_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      EXC_IDLE: begin
        if (bus.CauseWrite)
          nextState = EXC_HANDLER;
        else if (intEnable && anyActive && bus.InstrBoundary)
          nextState = EXC_PENDING;
      end
      EXC_PENDING: begin
        if (bus.CauseWrite) nextState = EXC_HANDLER;
      end
      EXC_HANDLER: begin
        if (bus.Eret) nextState = EXC_IDLE;
      end
      default: nextState = EXC_IDLE;
    endcase
  end

  // Status outputs follow the state register directly, so they are glitch-free
  // registered values; only the ack pulse is qualified by CauseWrite.
  always_comb begin
    excPending = (state == EXC_PENDING);
    inHandler  = (state == EXC_HANDLER);
    intEnable  = (state != EXC_HANDLER);
    irqService = (state == EXC_PENDING) && bus.CauseWrite;
    irqAck     = irqService ? (NUM_IRQ'(1) << frozenIdx) : '0;
  end

  always_comb begin
    causeIrq                = '0;
    causeIrq[CAUSE_EXT_BIT] = 1'b1;
    causeIrq[3:0]           = irq_code(frozenIdx);
    causeSw = bus.IntCause ? WIDTH'(CAUSE_ILLEGAL) : WIDTH'(CAUSE_SYSCALL);
  end

  // EPC is frozen inside the handler so a nested software exception keeps
  // the original return address.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      frozenIdx <= '0;
      epcReg    <= '0;
      causeReg  <= '0;
    end else begin
      if (state == EXC_IDLE && nextState == EXC_PENDING) frozenIdx <= selIndex;
      if (bus.CauseWrite)
        causeReg <= (state == EXC_PENDING) ? causeIrq : causeSw;
      if (bus.EPCWrite && state != EXC_HANDLER) epcReg <= bus.PC;
    end
  end

  assign bus.ExcPending    = excPending;
  assign bus.InHandler     = inHandler;
  assign bus.IntEnable     = intEnable;
  assign bus.IrqAck        = irqAck;
  assign bus.EPC           = epcReg;
  assign bus.Cause         = causeReg;
  assign bus.HandlerVector = HANDLER_ADDR;

endmodule

// File: tb/tb_exception_unit.sv
// Directed plus randomized checks of exception_unit against a behavioural
// model built from latches, a pending/handler flag pair and saved registers.
module tb_exception_unit;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  exception_unit_if #(.WIDTH(W), .NUM_IRQ(N)) bus ();

  exception_unit #(
    .WIDTH        (W),
    .NUM_IRQ      (N),
    .HANDLER_ADDR (16'h0100)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  bit           mPend, mHand;
  logic [N-1:0] mLatch, mPrev, mMask;
  int           mFrozen;
  logic [W-1:0] mEpc, mCause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mPend = 0; mHand = 0; mLatch = '0; mPrev = '0; mMask = '1;
    mFrozen = 0; mEpc = '0; mCause = '0;
  endtask

  // Applied once per rising edge using the inputs that were present before it.
  task automatic model_edge();
    logic [N-1:0] rise, active;
    int low;
    if (Reset) begin model_reset(); return; end
    rise = bus.ExtIrq & ~mPrev;
    active = mLatch & mMask;
    low = -1;
    for (int i = N - 1; i >= 0; i--) if (active[i]) low = i;
    if (mHand) begin
      if (bus.CauseWrite) mCause = {15'd0, bus.IntCause};
      if (bus.Eret) mHand = 0;
    end else if (mPend) begin
      if (bus.EPCWrite) mEpc = bus.PC;
      if (bus.CauseWrite) begin
        mCause = 16'h8000 | 16'(8 + mFrozen);
        mLatch[mFrozen] = 1'b0;
        mPend = 0; mHand = 1;
      end
    end else begin
      if (bus.EPCWrite) mEpc = bus.PC;
      if (bus.CauseWrite) begin
        mCause = {15'd0, bus.IntCause};
        mHand = 1;
      end else if (low >= 0 && bus.InstrBoundary) begin
        mPend = 1; mFrozen = low;
      end
    end
    mLatch = mLatch | rise;
    mPrev = bus.ExtIrq;
    if (bus.MaskWrite) mMask = bus.MaskData;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] ack;
    ack = (mPend && bus.CauseWrite) ? (N'(1) << mFrozen) : '0;
    chk({tag, ".ExcPending"}, 32'(bus.ExcPending), 32'(mPend));
    chk({tag, ".InHandler"},  32'(bus.InHandler),  32'(mHand));
    chk({tag, ".IntEnable"},  32'(bus.IntEnable),  32'(!mHand));
    chk({tag, ".EPC"},        32'(bus.EPC),        32'(mEpc));
    chk({tag, ".Cause"},      32'(bus.Cause),      32'(mCause));
    chk({tag, ".IrqAck"},     32'(bus.IrqAck),     32'(ack));
    chk({tag, ".Vector"},     32'(bus.HandlerVector), 32'h0100);
  endtask

  // Inputs are set just after a falling edge; check, take the rising edge, return at the next falling edge.
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic quiet();
    bus.CauseWrite = 0; bus.EPCWrite = 0; bus.InstrBoundary = 0;
    bus.Eret = 0; bus.MaskWrite = 0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.PC = '0; bus.IntCause = 0; bus.MaskData = '1; bus.ExtIrq = '0;
    quiet();
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check_all("reset");
    Reset = 1'b0;
    @(negedge CLK);

    // Single irq on line 2, accepted at a boundary two cycles after the edge.
    bus.ExtIrq = 4'b0100; tick("irq2_edge");
    tick("irq2_wait1");
    bus.InstrBoundary = 1; tick("irq2_bound");
    bus.InstrBoundary = 0;
    chk("irq2_pending", 32'(bus.ExcPending), 32'd1);
    bus.CauseWrite = 1; bus.EPCWrite = 1; bus.PC = 16'h0042;
    #1 chk("irq2_ack", 32'(bus.IrqAck), 32'(4'b0100));
    tick("irq2_service");
    quiet();
    #1;
    chk("irq2_cause", 32'(bus.Cause), 32'h800A);
    chk("irq2_epc", 32'(bus.EPC), 32'h0042);
    chk("irq2_inh", 32'(bus.InHandler), 32'd1);
    chk("irq2_ien", 32'(bus.IntEnable), 32'd0);
    chk("irq2_ack_once", 32'(bus.IrqAck), 32'd0);
    bus.Eret = 1; tick("irq2_eret");
    quiet(); bus.ExtIrq = '0; tick("irq2_drop");

    // Lines 3 and 1 together: lowest index first.
    bus.ExtIrq = 4'b1010; tick("two_edge");
    bus.ExtIrq = '0; bus.InstrBoundary = 1; tick("two_bound1");
    quiet(); bus.CauseWrite = 1; bus.EPCWrite = 1; bus.PC = 16'h0050; tick("two_svc1");
    quiet(); #1 chk("two_cause1", 32'(bus.Cause), 32'h8009);
    bus.Eret = 1; tick("two_eret1");
    quiet(); bus.InstrBoundary = 1; tick("two_bound2");
    quiet(); bus.CauseWrite = 1; bus.EPCWrite = 1; bus.PC = 16'h0060; tick("two_svc2");
    quiet(); #1 chk("two_cause2", 32'(bus.Cause), 32'h800B);
    bus.Eret = 1; tick("two_eret2");
    quiet(); tick("two_idle");

    // Software exception from IDLE.
    bus.IntCause = 1; bus.PC = 16'h0010; bus.CauseWrite = 1; bus.EPCWrite = 1;
    tick("sw_write");
    quiet(); #1;
    chk("sw_cause", 32'(bus.Cause), 32'h0001);
    chk("sw_epc", 32'(bus.EPC), 32'h0010);
    chk("sw_inh", 32'(bus.InHandler), 32'd1);
    bus.Eret = 1; tick("sw_eret");
    quiet(); #1;
    chk("sw_ien", 32'(bus.IntEnable), 32'd1);
    chk("sw_inh_clr", 32'(bus.InHandler), 32'd0);

    // Masked line stays latched until unmasked.
    bus.MaskWrite = 1; bus.MaskData = 4'b1110; tick("mask_set");
    quiet(); bus.ExtIrq = 4'b0001; tick("mask_edge");
    bus.ExtIrq = '0;
    for (int i = 0; i < 3; i++) begin bus.InstrBoundary = 1; tick("mask_bound"); end
    quiet(); #1 chk("mask_no_pend", 32'(bus.ExcPending), 32'd0);
    bus.MaskWrite = 1; bus.MaskData = 4'b1111; tick("mask_clear");
    quiet(); bus.InstrBoundary = 1; tick("unmask_bound");
    quiet(); #1 chk("unmask_pend", 32'(bus.ExcPending), 32'd1);
    bus.CauseWrite = 1; bus.EPCWrite = 1; bus.PC = 16'h0300; bus.IntCause = 0;
    tick("unmask_svc");
    quiet(); #1 chk("unmask_cause", 32'(bus.Cause), 32'h8008);

    // Nested software exception keeps EPC; new irq waits for Eret.
    bus.CauseWrite = 1; bus.EPCWrite = 1; bus.PC = 16'h0200; tick("nest_write");
    quiet(); #1;
    chk("nest_cause", 32'(bus.Cause), 32'h0000);
    chk("nest_epc", 32'(bus.EPC), 32'h0300);
    bus.ExtIrq = 4'b0100; tick("nest_edge");
    bus.ExtIrq = '0;
    for (int i = 0; i < 2; i++) begin bus.InstrBoundary = 1; tick("nest_bound"); end
    quiet(); #1 chk("nest_no_pend", 32'(bus.ExcPending), 32'd0);
    bus.Eret = 1; tick("nest_eret");
    quiet(); bus.InstrBoundary = 1; tick("post_bound");
    quiet(); #1 chk("post_pend", 32'(bus.ExcPending), 32'd1);

    // Asynchronous reset while pending.
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_pend", 32'(bus.ExcPending), 32'd0);
    @(negedge CLK);
    tick("rst_hold");
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin bus.InstrBoundary = 1; tick("rst_bound"); end
    quiet(); #1 chk("rst_no_pend", 32'(bus.ExcPending), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) bus.ExtIrq[b] = ~bus.ExtIrq[b];
      bus.InstrBoundary = ($urandom_range(0, 2) == 0);
      bus.CauseWrite    = ($urandom_range(0, 6) == 0);
      bus.EPCWrite      = bus.CauseWrite ? ($urandom_range(0, 7) != 0)
                                         : ($urandom_range(0, 15) == 0);
      bus.Eret          = ($urandom_range(0, 5) == 0);
      bus.MaskWrite     = ($urandom_range(0, 9) == 0);
      bus.MaskData      = N'($urandom);
      bus.IntCause      = 1'($urandom);
      bus.PC            = W'($urandom);
      tick("rand");
    end
    quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
